// File: rtl/match_controller.sv
// Innings sequencer: turns bowl presses into delivery strobes, counts balls/overs,
// and decides innings end, chase success and the match result from datapath readback.
module match_controller #(
  parameter int MAX_OVERS      = 5,
  parameter int BALLS_PER_OVER = 6
) (
  input  logic        clk_fpga,
  input  logic        reset,
  input  logic        bowl_btn,
  input  logic [3:0]  lfsr_out,
  input  logic [11:0] team1Data,
  input  logic [11:0] team2Data,
  output logic        delivery,
  output logic        teamSwitch,
  output logic        gameOver,
  output logic [2:0]  balls,
  output logic [3:0]  overs,
  output logic        innings_break,
  output logic [8:0]  target,
  output logic [1:0]  winner,
  output logic [2:0]  state_o
);

  typedef enum logic [2:0] {
    INN1  = 3'd0,
    DEL1  = 3'd1,
    CHK1  = 3'd2,
    BRK   = 3'd3,
    INN2  = 3'd4,
    DEL2  = 3'd5,
    CHK2  = 3'd6,
    DONE  = 3'd7
  } state_t;

  localparam logic [3:0] MAX_OV    = 4'(MAX_OVERS);
  localparam logic [2:0] LAST_BALL = 3'(BALLS_PER_OVER - 1);

  state_t      state_q, state_d;
  logic        delivery_q, delivery_d;
  logic        switch_q, switch_d;
  logic [2:0]  balls_q, balls_d;
  logic [3:0]  overs_q, overs_d;
  logic [8:0]  target_q, target_d;
  logic [1:0]  winner_q, winner_d;

  logic [7:0]  t1_runs, t2_runs;
  logic [3:0]  t1_wkts, t2_wkts;
  logic        legal_ball;

  assign t1_runs    = team1Data[11:4];
  assign t1_wkts    = team1Data[3:0];
  assign t2_runs    = team2Data[11:4];
  assign t2_wkts    = team2Data[3:0];
  assign legal_ball = (lfsr_out != 4'd13) && (lfsr_out != 4'd14);

  always_ff @(posedge clk_fpga or negedge reset) begin
    if (!reset) begin
      state_q    <= INN1;
      delivery_q <= 1'b0;
      switch_q   <= 1'b0;
      balls_q    <= '0;
      overs_q    <= '0;
      target_q   <= '0;
      winner_q   <= '0;
    end else begin
      state_q    <= state_d;
      delivery_q <= delivery_d;
      switch_q   <= switch_d;
      balls_q    <= balls_d;
      overs_q    <= overs_d;
      target_q   <= target_d;
      winner_q   <= winner_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    delivery_d = 1'b0;
    switch_d   = switch_q;
    balls_d    = balls_q;
    overs_d    = overs_q;
    target_d   = target_q;
    winner_d   = winner_q;
    case (state_q)
      INN1: if (bowl_btn) begin
        delivery_d = 1'b1;
        state_d    = DEL1;
      end
      INN2: if (bowl_btn) begin
        delivery_d = 1'b1;
        state_d    = DEL2;
      end
      DEL1, DEL2: begin
        // The datapath samples lfsr_out in this same cycle; extras leave the count alone.
        if (legal_ball) begin
          if (balls_q == LAST_BALL) begin
            balls_d = '0;
            overs_d = overs_q + 4'd1;
          end else begin
            balls_d = balls_q + 3'd1;
          end
        end
        state_d = (state_q == DEL1) ? CHK1 : CHK2;
      end
      CHK1: begin
        if (t1_wkts >= 4'd10 || overs_q == MAX_OV) begin
          state_d  = BRK;
          target_d = {1'b0, t1_runs} + 9'd1;
          switch_d = 1'b1;
          balls_d  = '0;
          overs_d  = '0;
        end else begin
          state_d = INN1;
        end
      end
      BRK: if (bowl_btn) state_d = INN2;
      CHK2: begin
        // Reaching the target wins even if the innings also ran out on this ball.
        if ({1'b0, t2_runs} >= target_q) begin
          state_d  = DONE;
          winner_d = 2'd2;
        end else if (t2_wkts >= 4'd10 || overs_q == MAX_OV) begin
          state_d = DONE;
          if (t1_runs > t2_runs)       winner_d = 2'd1;
          else if (t1_runs == t2_runs) winner_d = 2'd3;
          else                         winner_d = 2'd2;
        end else begin
          state_d = INN2;
        end
      end
      DONE: state_d = DONE;
      default: state_d = INN1;
    endcase
  end

  assign delivery      = delivery_q;
  assign teamSwitch    = switch_q;
  assign gameOver      = (state_q == DONE);
  assign innings_break = (state_q == BRK);
  assign balls         = balls_q;
  assign overs         = overs_q;
  assign target        = target_q;
  assign winner        = winner_q;
  assign state_o       = state_q;

endmodule

// File: doc/match_controller.md
Name: match_controller

Overview:
- Innings sequencer for the score/wickets datapath. Converts debounced bowl-button presses into single-cycle `delivery` pulses and drives `teamSwitch` and `gameOver`.
- Counts legal balls and overs and reads back `team1Data` / `team2Data` to detect innings end, target chase and match result.
- Sits between the button/LFSR front end and the score datapath. Its status outputs feed the display mux.

Parameters:
- MAX_OVERS, 5, overs per innings (1..15).
- BALLS_PER_OVER, 6, legal balls per over (2..7).

Ports:
- clk_fpga  input  1  system clock; all state on its rising edge.
- reset  input  1  asynchronous, active-low reset; state clears while reset==0.
- bowl_btn  input  1  debounced single-cycle press pulse.
- lfsr_out  input  4  outcome code shared with the datapath (13,14 = extra; 15 = wicket).
- team1Data  input  12  datapath readback; [11:4] runs, [3:0] wickets.
- team2Data  input  12  datapath readback, same format.
- delivery  output  1  one-cycle strobe to the datapath.
- teamSwitch  output  1  0 = team 1 batting, 1 = team 2 batting.
- gameOver  output  1  high in DONE; freezes the datapath.
- balls  output  3  legal balls in the current over.
- overs  output  4  completed overs in the current innings.
- innings_break  output  1  high in BREAK.
- target  output  9  team-1 runs + 1; 0 until BREAK is entered.
- winner  output  2  0 = undecided, 1 = team 1, 2 = team 2, 3 = tie.

Behaviour:
- Reset (reset==0, asynchronous): state = INN1; all outputs 0.
- States: INN1, DEL1, CHK1, BREAK, INN2, DEL2, CHK2, DONE.
- INNx: bowl_btn==1 -> register delivery<=1, go to DELx. Otherwise hold.
- DELx: delivery is high for exactly this cycle; the datapath samples lfsr_out in this same cycle. The controller samples lfsr_out here too:
  - If the code is a legal ball (not 13 or 14), balls increments.
  - If balls reaches BALLS_PER_OVER-1 and increments: balls<=0, overs<=overs+1.
  - delivery<=0. Go to CHKx.
- CHKx: the datapath registers now hold the post-delivery value. Decide from them.
- CHK1:
  - team1Data[3:0]>=10 or overs==MAX_OVERS -> go to BREAK; target<=team1Data[11:4]+1 (9-bit, no overflow).
  - Otherwise -> INN1.
- BREAK:
  - teamSwitch<=1 on entry; balls<=0, overs<=0.
  - bowl_btn -> INN2. The press that starts innings 2 does not bowl.
- CHK2, checked in this priority:
  1. team2 runs (9-bit compare) >= target -> DONE, winner=2.
  2. team2 wickets>=10 or overs==MAX_OVERS -> DONE; winner=1 if team1 runs > team2 runs, 3 if equal.
  3. Otherwise -> INN2.
- DONE: gameOver=1; the state is absorbing until reset. teamSwitch, balls, overs, target and winner hold.
- bowl_btn is ignored in DELx, CHKx and DONE; the press is dropped, not queued. Minimum spacing between deliveries is therefore 3 cycles.
- delivery is never high in BREAK or DONE, and never for two consecutive cycles.
- Extras (13,14) count runs in neither counter and leave balls/overs unchanged. A wicket (15) is a legal ball.
- The last legal ball of the last over and the 10th wicket on the same delivery produce a single transition; in CHK2 the target check wins over both.
- Reset mid-innings (including in DEL/CHK) returns to INN1 immediately; delivery drops asynchronously.

Test Plan:
- Reset then 6 presses, all lfsr_out=3 → 6 single-cycle delivery pulses; balls 1..5 then 0; overs=1 after the 6th; teamSwitch=0.
- lfsr_out=13 on a press → delivery pulses, balls/overs unchanged; next press with lfsr_out=0 → balls+1.
- Innings 1: 10 presses with lfsr_out=15, starting at team1Data=0x300 → BREAK after the 10th CHK1; target=49; teamSwitch=1; the next press enters INN2 with no delivery.
- Innings 2 with target=49; team2Data reaches runs 50 on a delivery → DONE next cycle, winner=2, gameOver=1; further presses produce no delivery.
- MAX_OVERS=1: team1 ends at 20 runs, team2 ends at 20 runs after 6 legal balls → winner=3. Repeat with team2 at 19 → winner=1.
- Press arriving during DEL1 or CHK1 → ignored. Drive reset=0 during CHK2 → all outputs 0 immediately, state INN1.
